// File: rtl/lsu_stb_pkg.sv
// Shared types and defaults for the LSU store-buffer state queue.
// No logic; constants and the per-entry state layout only.
// Optional high-water-mark output is controlled by LSU_STB_HWM_EN in lsu_stb_state_q.
package lsu_stb_pkg;

    localparam int STB_NUM_ENT = 8;
    localparam int STB_VA_W    = 2;
    localparam int STB_RTYPE_W = 2;

    // Request-type encodings held in the rtype field (rq_type[2:1]).
    localparam logic [STB_RTYPE_W-1:0] STB_RTYPE_ST   = 2'd0;
    localparam logic [STB_RTYPE_W-1:0] STB_RTYPE_BST  = 2'd1;
    localparam logic [STB_RTYPE_W-1:0] STB_RTYPE_ATOM = 2'd2;
    localparam logic [STB_RTYPE_W-1:0] STB_RTYPE_FLSH = 2'd3;

    // Per-entry state in the default configuration; rmo sits in the LSB.
    typedef struct packed {
        logic [STB_VA_W-1:0]    va;
        logic [STB_RTYPE_W-1:0] rtype;
        logic                   rmo;
    } stb_state_t;

endpackage

// File: rtl/lsu_stb_state_ent.sv
// One store-buffer state entry: unreset data flops plus an async-reset valid flop.
// Latency: write and valid set/clear visible one cycle after the enabling edge.
// Backpressure: none here; the queue only asserts wr_en when the entry is free.
module lsu_stb_state_ent
    import lsu_stb_pkg::*;
#(
    parameter int DW = $bits(stb_state_t)
) (
    input  logic          rclk,
    input  logic          arst_l,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dat,
    input  logic          clr_vld,
    input  logic          flush,
    output logic          vld,
    output logic [DW-1:0] dat
);

    logic          vld_d, vld_q;
    logic [DW-1:0] dat_d, dat_q;

    // Data holds unless this entry is the enqueue target.
    always_comb begin
        dat_d = dat_q;
        if (wr_en) begin
            dat_d = wr_dat;
        end
    end

    // Data flops carry no reset: contents are only meaningful while valid.
    always_ff @(posedge rclk) begin
        dat_q <= dat_d;
    end

    // Flush wins; a write sets valid, a dequeue clears it.
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (wr_en) begin
            vld_d = 1'b1;
        end else if (clr_vld) begin
            vld_d = 1'b0;
        end
    end

    // Valid flop with asynchronous active-low reset.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;

endmodule

// File: rtl/lsu_stb_state_q.sv
// Circular store-buffer state queue (va, rtype, rmo) for one thread; head exposed to PCX drain.
// Latency: enqueue/dequeue visible next cycle; head outputs are combinational from entry[rptr].
// Backpressure: enqueue while full is dropped and sets sticky stb_ovf; LSU_STB_HWM_EN adds stb_hwm.
module lsu_stb_state_q
    import lsu_stb_pkg::*;
#(
    parameter int NUM_ENT = STB_NUM_ENT,
    parameter int VA_W    = STB_VA_W,
    parameter int RTYPE_W = STB_RTYPE_W
) (
    input  logic                       rclk,
    input  logic                       arst_l,
    input  logic                       stb_wr_m,
    input  logic [VA_W-1:0]            stb_va_m,
    input  logic [RTYPE_W-1:0]         stb_rtype_m,
    input  logic                       stb_rmo_m,
    input  logic                       stb_deq,
    input  logic                       stb_flush,
    output logic                       stb_full,
    output logic                       stb_empty,
    output logic [$clog2(NUM_ENT):0]   stb_cnt,
    output logic                       stb_head_vld,
    output logic [VA_W-1:0]            stb_head_va,
    output logic [RTYPE_W-1:0]         stb_head_rtype,
    output logic                       stb_head_rmo,
    output logic [NUM_ENT-1:0]         stb_ent_vld,
    output logic [NUM_ENT-1:0]         stb_ent_rmo,
    output logic                       stb_ovf
`ifdef LSU_STB_HWM_EN
    ,
    output logic [$clog2(NUM_ENT):0]   stb_hwm
`endif
);

    localparam int PTR_W = $clog2(NUM_ENT);
    localparam int CNT_W = PTR_W + 1;
    localparam int DW    = VA_W + RTYPE_W + 1;

    logic [PTR_W-1:0] wptr_d, wptr_q;
    logic [PTR_W-1:0] rptr_d, rptr_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic             do_enq, do_deq;
    logic [DW-1:0]    wr_dat;
    logic [DW-1:0]    ent_dat [NUM_ENT];
    logic [DW-1:0]    head_dat;

    // Full/empty come from the counter so pointer equality is never ambiguous.
    assign stb_cnt   = cnt_q;
    assign stb_full  = (cnt_q == CNT_W'(NUM_ENT));
    assign stb_empty = (cnt_q == '0);
    assign stb_ovf   = ovf_q;

    // Flush kills both sides; a dequeue against an empty head is ignored.
    assign do_enq = stb_wr_m && !stb_full && !stb_flush;
    assign do_deq = stb_deq && stb_head_vld && !stb_flush;
    assign wr_dat = {stb_va_m, stb_rtype_m, stb_rmo_m};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENT; gi++) begin : g_ent
            lsu_stb_state_ent #(
                .DW (DW)
            ) u_ent (
                .rclk    (rclk),
                .arst_l  (arst_l),
                .wr_en   (do_enq && (wptr_q == PTR_W'(gi))),
                .wr_dat  (wr_dat),
                .clr_vld (do_deq && (rptr_q == PTR_W'(gi))),
                .flush   (stb_flush),
                .vld     (stb_ent_vld[gi]),
                .dat     (ent_dat[gi])
            );
            assign stb_ent_rmo[gi] = ent_dat[gi][0] & stb_ent_vld[gi];
        end
    endgenerate

    // Head fields are valid-gated so stale entry data never leaks out.
    assign head_dat       = ent_dat[rptr_q];
    assign stb_head_vld   = stb_ent_vld[rptr_q];
    assign stb_head_va    = head_dat[DW-1 -: VA_W] & {VA_W{stb_head_vld}};
    assign stb_head_rtype = head_dat[RTYPE_W:1] & {RTYPE_W{stb_head_vld}};
    assign stb_head_rmo   = head_dat[0] & stb_head_vld;

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (stb_flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (stb_wr_m && stb_full) begin
                ovf_d = 1'b1;
            end
            if (do_enq) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (do_deq) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef LSU_STB_HWM_EN
    logic [CNT_W-1:0] hwm_d, hwm_q;

    // High-water mark tracks the peak of the next occupancy; flush does not clear it.
    always_comb begin
        hwm_d = hwm_q;
        if (cnt_d > hwm_q) begin
            hwm_d = cnt_d;
        end
    end

    // High-water-mark flop, cleared only by reset.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign stb_hwm = hwm_q;
`endif

endmodule

// File: tb/tb_lsu_stb_state_q.sv
// Self-checking bench for lsu_stb_state_q: directed scenarios then random traffic.
// Reference model is a FIFO of {slot, state}; outputs sampled 1ns after each rising edge.
// Define LSU_STB_HWM_EN at compile time to also check the high-water mark.
module tb_lsu_stb_state_q;
    import lsu_stb_pkg::*;

    localparam int N = 8;

    logic rclk = 1'b0;
    logic arst_l;
    logic stb_wr_m;
    logic [1:0] stb_va_m;
    logic [1:0] stb_rtype_m;
    logic stb_rmo_m;
    logic stb_deq;
    logic stb_flush;
    logic stb_full;
    logic stb_empty;
    logic [3:0] stb_cnt;
    logic stb_head_vld;
    logic [1:0] stb_head_va;
    logic [1:0] stb_head_rtype;
    logic stb_head_rmo;
    logic [N-1:0] stb_ent_vld;
    logic [N-1:0] stb_ent_rmo;
    logic stb_ovf;
`ifdef LSU_STB_HWM_EN
    logic [3:0] stb_hwm;
`endif

    lsu_stb_state_q #(.NUM_ENT(N), .VA_W(2), .RTYPE_W(2)) dut (
        .rclk           (rclk),
        .arst_l         (arst_l),
        .stb_wr_m       (stb_wr_m),
        .stb_va_m       (stb_va_m),
        .stb_rtype_m    (stb_rtype_m),
        .stb_rmo_m      (stb_rmo_m),
        .stb_deq        (stb_deq),
        .stb_flush      (stb_flush),
        .stb_full       (stb_full),
        .stb_empty      (stb_empty),
        .stb_cnt        (stb_cnt),
        .stb_head_vld   (stb_head_vld),
        .stb_head_va    (stb_head_va),
        .stb_head_rtype (stb_head_rtype),
        .stb_head_rmo   (stb_head_rmo),
        .stb_ent_vld    (stb_ent_vld),
        .stb_ent_rmo    (stb_ent_rmo),
        .stb_ovf        (stb_ovf)
`ifdef LSU_STB_HWM_EN
        ,
        .stb_hwm        (stb_hwm)
`endif
    );

    always #5 rclk = ~rclk;

    // Reference model: queue in arrival order, each remembering the slot it was written to.
    typedef struct {
        int         slot;
        stb_state_t st;
    } mdl_ent_t;

    mdl_ent_t mq[$];
    int       m_wslot;
    bit       m_ovf;
    int       m_hwm;

    int checks;
    int failures;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mq.delete();
        m_wslot = 0;
        m_ovf   = 1'b0;
        m_hwm   = 0;
    endtask

    // Apply one cycle of the current inputs to the model.
    task automatic mdl_step();
        mdl_ent_t e;
        bit       was_full;
        bit       was_empty;
        was_full  = (mq.size() == N);
        was_empty = (mq.size() == 0);
        if (stb_flush) begin
            mq.delete();
            m_wslot = 0;
        end else begin
            if (stb_wr_m && was_full) m_ovf = 1'b1;
            if (stb_deq && !was_empty) void'(mq.pop_front());
            if (stb_wr_m && !was_full) begin
                e.slot     = m_wslot;
                e.st.va    = stb_va_m;
                e.st.rtype = stb_rtype_m;
                e.st.rmo   = stb_rmo_m;
                mq.push_back(e);
                m_wslot = (m_wslot + 1) % N;
            end
        end
        if (mq.size() > m_hwm) m_hwm = mq.size();
    endtask

    task automatic compare_all(input string pfx);
        logic [N-1:0] ev;
        logic [N-1:0] er;
        ev = '0;
        er = '0;
        foreach (mq[k]) begin
            ev[mq[k].slot] = 1'b1;
            er[mq[k].slot] = mq[k].st.rmo;
        end
        chk({pfx, "_cnt"},      32'(stb_cnt),       32'(mq.size()));
        chk({pfx, "_full"},     32'(stb_full),      32'(mq.size() == N));
        chk({pfx, "_empty"},    32'(stb_empty),     32'(mq.size() == 0));
        chk({pfx, "_head_vld"}, 32'(stb_head_vld),  32'(mq.size() != 0));
        chk({pfx, "_head_va"},  32'(stb_head_va),   (mq.size() != 0) ? 32'(mq[0].st.va)    : 32'd0);
        chk({pfx, "_head_rt"},  32'(stb_head_rtype),(mq.size() != 0) ? 32'(mq[0].st.rtype) : 32'd0);
        chk({pfx, "_head_rmo"}, 32'(stb_head_rmo),  (mq.size() != 0) ? 32'(mq[0].st.rmo)   : 32'd0);
        chk({pfx, "_ent_vld"},  32'(stb_ent_vld),   32'(ev));
        chk({pfx, "_ent_rmo"},  32'(stb_ent_rmo),   32'(er));
        chk({pfx, "_ovf"},      32'(stb_ovf),       32'(m_ovf));
`ifdef LSU_STB_HWM_EN
        chk({pfx, "_hwm"},      32'(stb_hwm),       32'(m_hwm));
`endif
    endtask

    // Drive one cycle of stimulus, clock it, and compare 1ns after the edge.
    task automatic cyc(input string pfx, input bit wr, input logic [1:0] va, input logic [1:0] rt,
                       input bit rmo, input bit deq, input bit fl);
        stb_wr_m    = wr;
        stb_va_m    = va;
        stb_rtype_m = rt;
        stb_rmo_m   = rmo;
        stb_deq     = deq;
        stb_flush   = fl;
        mdl_step();
        @(posedge rclk);
        #1;
        stb_wr_m  = 1'b0;
        stb_deq   = 1'b0;
        stb_flush = 1'b0;
        compare_all(pfx);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string pfx);
        #3;
        arst_l = 1'b0;
        #1;
        mdl_reset();
        compare_all(pfx);
        #2;
        arst_l = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        arst_l      = 1'b0;
        stb_wr_m    = 1'b0;
        stb_va_m    = '0;
        stb_rtype_m = '0;
        stb_rmo_m   = 1'b0;
        stb_deq     = 1'b0;
        stb_flush   = 1'b0;
        mdl_reset();
        #12;
        compare_all("rst");
        chk("rst_empty_const", 32'(stb_empty), 32'd1);
        arst_l = 1'b1;

        // Three stores: va 1,2,3 with rmo 0,1,0.
        cyc("t1a", 1, 2'd1, STB_RTYPE_ST,   1'b0, 0, 0);
        cyc("t1b", 1, 2'd2, STB_RTYPE_BST,  1'b1, 0, 0);
        cyc("t1c", 1, 2'd3, STB_RTYPE_ATOM, 1'b0, 0, 0);
        chk("t1_cnt_const",     32'(stb_cnt),     32'd3);
        chk("t1_ent_vld_const", 32'(stb_ent_vld), 32'h07);
        chk("t1_ent_rmo_const", 32'(stb_ent_rmo), 32'h02);
        chk("t1_head_va_const", 32'(stb_head_va), 32'd1);

        // Fill to 8, then overflow attempt; entry 0 must still be the head.
        for (int i = 0; i < 5; i++) cyc("fill", 1, 2'(i), 2'(i + 1), 1'(i), 0, 0);
        cyc("ovf", 1, 2'd0, STB_RTYPE_FLSH, 1'b1, 0, 0);
        chk("t2_full_const", 32'(stb_full),    32'd1);
        chk("t2_cnt_const",  32'(stb_cnt),     32'd8);
        chk("t2_ovf_const",  32'(stb_ovf),     32'd1);
        chk("t2_ent0_va",    32'(stb_head_va), 32'd1);
        // Full with enqueue and dequeue together: the enqueue is still dropped.
        cyc("ovf_deq", 1, 2'd3, 2'd3, 1'b1, 1, 0);
        chk("t2_nofull_const", 32'(stb_full), 32'd0);
        chk("t2_ovf_sticky",   32'(stb_ovf),  32'd1);

        // Drop to 4 entries, then 20 enqueue+dequeue pairs (pointers wrap).
        for (int i = 0; i < 3; i++) cyc("to4", 0, 2'd0, 2'd0, 1'b0, 1, 0);
        for (int i = 0; i < 20; i++) cyc("pair", 1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                                         1'($urandom_range(0, 1)), 1, 0);
        chk("t3_cnt_const", 32'(stb_cnt), 32'd4);

        // Drain to empty, then enqueue+dequeue into an empty queue.
        for (int i = 0; i < N + 2 && mq.size() != 0; i++) cyc("drain", 0, 2'd0, 2'd0, 1'b0, 1, 0);
        chk("t4_drained", 32'(stb_empty), 32'd1);
        cyc("emptypair", 1, 2'd2, 2'd1, 1'b0, 1, 0);
        chk("t4_cnt_const",  32'(stb_cnt),      32'd1);
        chk("t4_hvld_const", 32'(stb_head_vld), 32'd1);
        chk("t4_hva_const",  32'(stb_head_va),  32'd2);

        // Five valid, then flush with enqueue and dequeue; next enqueue lands in entry 0.
        for (int i = 0; i < 4; i++) cyc("to5", 1, 2'(i), 2'd0, 1'b1, 0, 0);
        cyc("flush", 1, 2'd3, 2'd3, 1'b1, 1, 1);
        chk("t5_cnt_const",   32'(stb_cnt),     32'd0);
        chk("t5_empty_const", 32'(stb_empty),   32'd1);
        chk("t5_vld_const",   32'(stb_ent_vld), 32'd0);
        chk("t5_ovf_kept",    32'(stb_ovf),     32'd1);
        cyc("postflush", 1, 2'd1, 2'd2, 1'b0, 0, 0);
        chk("t5_ent0_const",  32'(stb_ent_vld), 32'h01);

        // Fresh reset, peak of 6, then asynchronous reset mid-burst.
        async_reset("rst2");
        for (int i = 0; i < 6; i++) cyc("to6", 1, 2'(i), 2'(i), 1'(i), 0, 0);
        cyc("burst", 1, 2'd1, 2'd1, 1'b0, 1, 0);
        cyc("burst", 1, 2'd2, 2'd2, 1'b1, 1, 0);
`ifdef LSU_STB_HWM_EN
        chk("t6_hwm_pre", 32'(stb_hwm), 32'd6);
`endif
        async_reset("rst3");
        chk("t6_cnt_const",  32'(stb_cnt),   32'd0);
        chk("t6_empty_const",32'(stb_empty), 32'd1);
`ifdef LSU_STB_HWM_EN
        chk("t6_hwm_post", 32'(stb_hwm), 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", 1'($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 99) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_stb_state_q.md
Name: lsu_stb_state_q

Overview:
- Parametrised store-buffer state queue for one thread; successor to the fixed 8-entry per-entry state flops.
- Tracks the per-entry fields va[7:6], request type and RMO in a circular buffer: write pointer, read pointer, valid bits and occupancy.
- Sits between the LSU M-stage store issue path and the PCX store-drain logic.
- Exposes the head entry to the drain logic, plus per-entry valid and RMO vectors for ordering checks.

Parameters:
NUM_ENT, 8, number of entries; power of two, 2..32
VA_W, 2, stored VA index bits (va[7:6] in the default configuration)
RTYPE_W, 2, stored request-type bits (rq_type[2:1] in the default configuration)

Ports:
rclk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
stb_wr_m  in  1  enqueue strobe; one store per cycle
stb_va_m  in  VA_W  VA index of the store being enqueued
stb_rtype_m  in  RTYPE_W  request type of the store being enqueued
stb_rmo_m  in  1  store is RMO (relaxed ordering)
stb_deq  in  1  drain logic has accepted the head entry
stb_flush  in  1  kill all entries (trap or thread flush)
stb_full  out  1  count == NUM_ENT
stb_empty  out  1  count == 0
stb_cnt  out  $clog2(NUM_ENT)+1  current occupancy
stb_head_vld  out  1  head entry valid
stb_head_va  out  VA_W  head entry VA index
stb_head_rtype  out  RTYPE_W  head entry request type
stb_head_rmo  out  1  head entry RMO bit
stb_ent_vld  out  NUM_ENT  per-entry valid bits
stb_ent_rmo  out  NUM_ENT  per-entry RMO bits, qualified by valid
stb_ovf  out  1  sticky error: enqueue attempted while full

Behaviour:
- Reset (arst_l low, asynchronous): wptr=0, rptr=0, all valids=0, stb_ovf=0.
- Reset consequences: stb_empty=1, stb_full=0, stb_cnt=0, stb_head_vld=0. Head data fields read 0 because they are valid-gated.
- Entry data flops are not reset. They are written only on enqueue.
- Enqueue: stb_wr_m && !stb_full at posedge.
  - Write the fields into entry[wptr] and set valid[wptr].
  - wptr increments modulo NUM_ENT.
  - Visible on the outputs the next cycle (1-cycle latency).
- Enqueue while full: the store is dropped, no state changes except stb_ovf<=1.
  - stb_ovf clears only on reset.
  - A dequeue in the same cycle does not make room; stb_full is evaluated on current-cycle state.
- Dequeue: stb_deq && stb_head_vld.
  - Clear valid[rptr]; rptr increments modulo NUM_ENT.
  - stb_deq while empty is ignored.
- Simultaneous enqueue and dequeue (not full, not empty): both take effect and stb_cnt is unchanged.
- Enqueue into an empty queue with stb_deq high: the dequeue is ignored and the new entry appears at the head the next cycle.
- Head outputs are combinational from entry[rptr], gated by valid[rptr].
- stb_cnt is a registered counter: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
- stb_full and stb_empty are decoded from stb_cnt. The invariant stb_cnt == popcount(valid) must hold.
- Wrap-around: pointers are $clog2(NUM_ENT) bits and wrap naturally. full versus empty is disambiguated by stb_cnt, not by pointer compare.
- Flush has priority over enqueue and dequeue in the same cycle.
  - Clears all valids; wptr=rptr=0; cnt=0.
  - stb_ovf is preserved.
  - A concurrent enqueue is discarded.
- stb_ent_rmo[i] = rmo[i] & valid[i].

Optional Feature:
- Macro: LSU_STB_HWM_EN.
- Defined:
  - Adds output stb_hwm [$clog2(NUM_ENT):0], the high-water mark of stb_cnt.
  - Updated each cycle to max(stb_hwm, next stb_cnt).
  - Reset to 0 by arst_l; not cleared by stb_flush.
- Undefined: the port is absent and no flops are inferred.

Decomposition:
- Shared package lsu_stb_pkg holds:
  - STB_RTYPE_* request-type encodings
  - the default NUM_ENT/VA_W/RTYPE_W constants
  - a packed struct stb_state_t {va, rtype, rmo}
- One sub-module is natural: lsu_stb_state_ent.
  - One entry: data flops with write enable, plus a valid flop with async reset, set and clear.
  - The queue instantiates it NUM_ENT times via generate.
- Pointer, counter and head-mux logic stay in the top module.

Test Plan:
- Reset, then enqueue 3 stores (va=1,2,3; rmo=0,1,0).
  - Next cycle: cnt=3, ent_vld=8'b0000_0111, ent_rmo=8'b0000_0010, head_va=1.
- Fill 8 stores, then a 9th with stb_wr_m.
  - full=1, cnt=8, ovf=1; entry 0 unchanged.
  - Dequeue one: full=0, ovf stays 1.
- Run 20 enqueue+dequeue pairs with cnt held at 4.
  - Pointers wrap twice; cnt stays 4.
  - Head values come out in exact FIFO order (va sequence checked against a scoreboard).
- Queue empty; stb_wr_m=1 and stb_deq=1 in the same cycle with va=2.
  - Next cycle: cnt=1, head_vld=1, head_va=2.
- With 5 entries valid, stb_flush=1 together with stb_wr_m=1 and stb_deq=1.
  - Next cycle: cnt=0, empty=1, ent_vld=0.
  - The following enqueue lands in entry 0.
- Drop arst_l mid-burst (asynchronous, between clock edges).
  - Outputs go to reset values immediately.
  - With LSU_STB_HWM_EN defined and peak cnt 6 before reset: hwm=6 before reset and 0 after.
